// File: rtl/fan_cfg_pkg.sv
// Shared constants and types for the fan coefficient loader.
//   FRAME_LEN   - serial frame length in bits for the default field widths
//                 ({addr[3:0], data[7:0]})
//   ADDR_*      - address map of the configuration frame
//   cfg_state_e - frame/commit controller states
package fan_cfg_pkg;

  localparam int FRAME_LEN = 12;

  localparam logic [3:0] ADDR_B2     = 4'h0;
  localparam logic [3:0] ADDR_B1     = 4'h1;
  localparam logic [3:0] ADDR_B0     = 4'h2;
  localparam logic [3:0] ADDR_A1     = 4'h3;
  localparam logic [3:0] ADDR_A0     = 4'h4;
  localparam logic [3:0] ADDR_PERIOD = 4'h5;
  localparam logic [3:0] ADDR_MIN    = 4'h6;
  localparam logic [3:0] ADDR_COMMIT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2,
    ST_PEND   = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/cfg_sync_edge.sv
// Two-flop synchroniser with edge detection for one asynchronous input.
//   clk_i   - system clock
//   rstn_i  - asynchronous active-low reset
//   din_i   - asynchronous input pin
//   level_o - synchronised level (stage 2)
//   rise_o  - one-cycle pulse on a synchronised rising edge
//   fall_o  - one-cycle pulse on a synchronised falling edge
// Every serial input uses its own instance, so all three see the same delay.
module cfg_sync_edge (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1, s2, s3;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level_o = s2;
  assign rise_o  = s2 & ~s3;
  assign fall_o  = ~s2 & s3;

endmodule

// File: rtl/fan_coeff_loader.sv
// Run-time configuration controller for the fan PI datapath.
// Addressed frames arrive over a 3-wire serial link (sclk/sdata/load) and
// land in shadow registers; a commit frame arms a copy of the whole shadow
// set to the active outputs, performed right after the next PID tick.
//   clk_i, rstn_i          - system clock, asynchronous active-low reset
//   cfg_sclk_i             - serial clock (data taken on its rising edge)
//   cfg_sdata_i            - serial data, MSB first
//   cfg_load_i             - frame enable, high for one whole frame
//   pid_tick_i             - one-cycle PID sample boundary pulse
//   b2_o..a0_o             - active signed coefficients (raw two's complement)
//   pwm_period_o/pwm_min_o - active PWM period / minimum counter values
//   busy_o                 - commit pending
//   cfg_err_o              - one-cycle pulse on a rejected frame or commit
//   cfg_done_o             - one-cycle pulse when the active set updates
module fan_coeff_loader
  import fan_cfg_pkg::*;
#(
  parameter int ADC_BITWIDTH = 4,
  parameter int COEF_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int DEF_B2       = 94,
  parameter int DEF_B1       = -93,
  parameter int DEF_B0       = 0,
  parameter int DEF_A1       = -64,
  parameter int DEF_A0       = 0,
  parameter int DEF_PERIOD   = 18,
  parameter int DEF_MIN      = 3
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    cfg_sclk_i,
  input  logic                    cfg_sdata_i,
  input  logic                    cfg_load_i,
  input  logic                    pid_tick_i,
  output logic [COEF_WIDTH-1:0]   b2_o,
  output logic [COEF_WIDTH-1:0]   b1_o,
  output logic [COEF_WIDTH-1:0]   b0_o,
  output logic [COEF_WIDTH-1:0]   a1_o,
  output logic [COEF_WIDTH-1:0]   a0_o,
  output logic [ADC_BITWIDTH:0]   pwm_period_o,
  output logic [ADC_BITWIDTH-1:0] pwm_min_o,
  output logic                    busy_o,
  output logic                    cfg_err_o,
  output logic                    cfg_done_o
);

  localparam int FLEN = ADDR_WIDTH + COEF_WIDTH;
  localparam int CW   = $clog2(FLEN + 1);
  localparam int PW   = ADC_BITWIDTH + 1;
  localparam int MW   = ADC_BITWIDTH;

  localparam logic [COEF_WIDTH-1:0] RST_B2  = COEF_WIDTH'(DEF_B2);
  localparam logic [COEF_WIDTH-1:0] RST_B1  = COEF_WIDTH'(DEF_B1);
  localparam logic [COEF_WIDTH-1:0] RST_B0  = COEF_WIDTH'(DEF_B0);
  localparam logic [COEF_WIDTH-1:0] RST_A1  = COEF_WIDTH'(DEF_A1);
  localparam logic [COEF_WIDTH-1:0] RST_A0  = COEF_WIDTH'(DEF_A0);
  localparam logic [PW-1:0]         RST_PER = PW'(DEF_PERIOD);
  localparam logic [MW-1:0]         RST_MIN = MW'(DEF_MIN);

  // Synchronised serial inputs
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sdata_lvl, sdata_rise, sdata_fall;
  logic load_lvl, load_rise, load_fall;

  cfg_sync_edge u_sync_sclk (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .din_i  (cfg_sclk_i),
    .level_o(sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  cfg_sync_edge u_sync_sdata (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .din_i  (cfg_sdata_i),
    .level_o(sdata_lvl),
    .rise_o (sdata_rise),
    .fall_o (sdata_fall)
  );

  cfg_sync_edge u_sync_load (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .din_i  (cfg_load_i),
    .level_o(load_lvl),
    .rise_o (load_rise),
    .fall_o (load_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_lvl, sclk_fall, sdata_rise, sdata_fall, load_lvl};

  // Frame assembly and shadow set
  cfg_state_e              state;
  logic [FLEN-1:0]         shreg;
  logic [CW-1:0]           cnt;
  logic                    overrun;
  logic [COEF_WIDTH-1:0]   sh_b2, sh_b1, sh_b0, sh_a1, sh_a0;
  logic [PW-1:0]           sh_per;
  logic [MW-1:0]           sh_min;

  logic [ADDR_WIDTH-1:0]   frm_addr;
  logic [COEF_WIDTH-1:0]   frm_data;
  logic                    frm_bad;
  logic                    min_ge_per;

  assign frm_addr   = shreg[FLEN-1 -: ADDR_WIDTH];
  assign frm_data   = shreg[COEF_WIDTH-1:0];
  assign frm_bad    = (cnt != CW'(FLEN)) || overrun;
  assign min_ge_per = ({1'b0, sh_min} >= sh_per);

  // busy_o is kept apart from the state so a frame arriving while a commit
  // is pending can still walk SHIFT/DECODE for framing and then fall back
  // to PEND; the shadow set is never written while busy_o is high.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      cnt          <= '0;
      overrun      <= 1'b0;
      sh_b2        <= RST_B2;
      sh_b1        <= RST_B1;
      sh_b0        <= RST_B0;
      sh_a1        <= RST_A1;
      sh_a0        <= RST_A0;
      sh_per       <= RST_PER;
      sh_min       <= RST_MIN;
      b2_o         <= RST_B2;
      b1_o         <= RST_B1;
      b0_o         <= RST_B0;
      a1_o         <= RST_A1;
      a0_o         <= RST_A0;
      pwm_period_o <= RST_PER;
      pwm_min_o    <= RST_MIN;
      busy_o       <= 1'b0;
      cfg_err_o    <= 1'b0;
      cfg_done_o   <= 1'b0;
    end else begin
      cfg_err_o  <= 1'b0;
      cfg_done_o <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (load_rise) begin
            state   <= ST_SHIFT;
            cnt     <= '0;
            overrun <= 1'b0;
          end
        end

        ST_PEND: begin
          if (pid_tick_i) begin
            b2_o         <= sh_b2;
            b1_o         <= sh_b1;
            b0_o         <= sh_b0;
            a1_o         <= sh_a1;
            a0_o         <= sh_a0;
            pwm_period_o <= sh_per;
            pwm_min_o    <= sh_min;
            cfg_done_o   <= 1'b1;
            busy_o       <= 1'b0;
          end
          // A frame starting in the same cycle as the tick is not lost.
          if (load_rise) begin
            state   <= ST_SHIFT;
            cnt     <= '0;
            overrun <= 1'b0;
          end else if (pid_tick_i) begin
            state <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          if (sclk_rise) begin
            if (cnt == CW'(FLEN)) begin
              overrun <= 1'b1;
            end else begin
              shreg <= {shreg[FLEN-2:0], sdata_lvl};
              cnt   <= cnt + CW'(1);
            end
          end
          if (load_fall) begin
            state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          state <= busy_o ? ST_PEND : ST_IDLE;
          if (frm_bad || busy_o) begin
            cfg_err_o <= 1'b1;
          end else begin
            case (frm_addr)
              ADDR_WIDTH'(ADDR_B2):     sh_b2  <= frm_data;
              ADDR_WIDTH'(ADDR_B1):     sh_b1  <= frm_data;
              ADDR_WIDTH'(ADDR_B0):     sh_b0  <= frm_data;
              ADDR_WIDTH'(ADDR_A1):     sh_a1  <= frm_data;
              ADDR_WIDTH'(ADDR_A0):     sh_a0  <= frm_data;
              ADDR_WIDTH'(ADDR_PERIOD): sh_per <= frm_data[PW-1:0];
              ADDR_WIDTH'(ADDR_MIN):    sh_min <= frm_data[MW-1:0];
              ADDR_WIDTH'(ADDR_COMMIT): begin
                if (min_ge_per) begin
                  cfg_err_o <= 1'b1;
                end else begin
                  busy_o <= 1'b1;
                  state  <= ST_PEND;
                end
              end
              default: cfg_err_o <= 1'b1;
            endcase
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
